// File: rtl/pipe_decoder_if.sv
// pipe_decoder_if -- request/response bundle for pipe_decoder.
//   master : requester side (drives en, in_valid, mode, in)
//   slave  : decoder side  (drives in_ready, out, out_valid, idx, wrap)
//   en        block enable, low clears the decoder
//   in_valid  request valid;  in_ready  decoder can accept
//   mode      0 = direct decode, 1 = scan (sampled on accept)
//   in        select code (sampled on accept)
//   out       registered one-hot decode, idx its binary index
//   out_valid out holds a valid one-hot value
//   wrap      one-cycle pulse when a scan rotates from the top index to 0
interface pipe_decoder_if #(
  parameter int SEL_W = 4
);
  logic                   en;
  logic                   in_valid;
  logic                   in_ready;
  logic                   mode;
  logic [SEL_W-1:0]       in;
  logic [(2**SEL_W)-1:0]  out;
  logic                   out_valid;
  logic [SEL_W-1:0]       idx;
  logic                   wrap;

  modport master (
    output en, in_valid, mode, in,
    input  in_ready, out, out_valid, idx, wrap
  );

  modport slave (
    input  en, in_valid, mode, in,
    output in_ready, out, out_valid, idx, wrap
  );
endinterface

// File: rtl/pipe_decoder.sv
// pipe_decoder -- registered binary-to-one-hot decoder with optional scan.
// A request accepted with mode=0 loads a one-hot value and holds it; with
// mode=1 the loaded bit then rotates left, one position every DWELL cycles,
// until en drops or reset. wrap pulses when the rotation passes top -> 0.
// Scan support is compiled in only when DECODER_SCAN_EN is defined; without
// it, mode is ignored and wrap is tied low.
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset
//   bus  pipe_decoder_if.slave (en, in_valid/in_ready, mode, in,
//        out, out_valid, idx, wrap)
// Parameters: SEL_W select width (out is 2**SEL_W), DWELL 1..255.
module pipe_decoder #(
  parameter int SEL_W = 4,
  parameter int DWELL = 1
) (
  input logic           clk,
  input logic           rst,
  pipe_decoder_if.slave bus
);
  localparam int OUT_W = 2**SEL_W;
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

`ifdef DECODER_SCAN_EN
  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

  state_t           state, nxt_state;
  logic [SEL_W-1:0] idx_q, nxt_idx;
  logic             vld_q, nxt_vld;
  logic             wrap_q, nxt_wrap;
  logic [OUT_W-1:0] out_q, nxt_out;
  logic             accept;

`ifdef DECODER_SCAN_EN
  logic [7:0] cnt_q, nxt_cnt;
  assign bus.in_ready = bus.en & (state != SCAN);
`else
  logic       unused_mode;
  logic [7:0] unused_dwell;
  assign unused_mode  = bus.mode;
  assign unused_dwell = DWELL_LAST;
  assign bus.in_ready = bus.en;
`endif

  assign accept = bus.en & bus.in_valid & bus.in_ready;

  // next-state / next-output; en low wins over accept and scan stepping
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx_q;
    nxt_vld   = vld_q;
    nxt_wrap  = 1'b0;
`ifdef DECODER_SCAN_EN
    nxt_cnt   = cnt_q;
`endif
    if (!bus.en) begin
      nxt_state = IDLE;
      nxt_idx   = '0;
      nxt_vld   = 1'b0;
`ifdef DECODER_SCAN_EN
      nxt_cnt   = '0;
`endif
    end else if (accept) begin
      nxt_idx = bus.in;
      nxt_vld = 1'b1;
`ifdef DECODER_SCAN_EN
      nxt_cnt   = '0;
      nxt_state = bus.mode ? SCAN : HOLD;
`else
      nxt_state = HOLD;
`endif
    end
`ifdef DECODER_SCAN_EN
    else if (state == SCAN) begin
      if (cnt_q == DWELL_LAST) begin
        nxt_cnt  = '0;
        nxt_idx  = idx_q + SEL_W'(1);
        // only a rotation out of the top bit produces wrap, never a load
        nxt_wrap = &idx_q;
      end else begin
        nxt_cnt = cnt_q + 8'd1;
      end
    end
`endif
  end

  // out is rebuilt from idx/valid so the one-hot always tracks idx
  for (genvar i = 0; i < OUT_W; i++) begin : g_dec
    assign nxt_out[i] = nxt_vld & (nxt_idx == SEL_W'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      wrap_q <= 1'b0;
      out_q  <= '0;
    end else begin
      state  <= nxt_state;
      idx_q  <= nxt_idx;
      vld_q  <= nxt_vld;
      wrap_q <= nxt_wrap;
      out_q  <= nxt_out;
    end
  end

`ifdef DECODER_SCAN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= nxt_cnt;
  end
`endif

  assign bus.out       = out_q;
  assign bus.idx       = idx_q;
  assign bus.out_valid = vld_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: doc/pipe_decoder.md
PIPE_DECODER -- requirements
Module: pipe_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 4: select width; output width is 2**SEL_W.
REQ-002 SHALL have parameter DWELL, default 1: cycles each one-hot position is held in scan mode; legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port en  input  1  block enable; low forces output clear.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port mode  input  1  0 = direct decode, 1 = scan; sampled on accept.
REQ-009 SHALL have port in  input  SEL_W  select code; sampled on accept.
REQ-010 SHALL have port out  output  2**SEL_W  registered one-hot decode.
REQ-011 SHALL have port out_valid  output  1  out holds a valid one-hot value.
REQ-012 SHALL have port idx  output  SEL_W  binary index of the asserted out bit.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse when scan wraps from top index to 0.

Function
REQ-014 SHALL implement FSM states IDLE, HOLD, SCAN.
REQ-015 SHALL accept a request on a rising edge when en & in_valid & in_ready.
REQ-016 SHALL drive in_ready = en & (state != SCAN), combinationally.
REQ-017 On accept with mode=0, SHALL register out = 1<<in, idx = in, out_valid = 1, state HOLD; latency one cycle.
REQ-018 On accept with mode=1, SHALL register out = 1<<in, idx = in, out_valid = 1, dwell counter = 0, state SCAN.
REQ-019 In HOLD, SHALL keep out/idx constant until a new accept replaces them (back-to-back accepts allowed every cycle).
REQ-020 In SCAN, SHALL increment the dwell counter each cycle; when it equals DWELL-1, SHALL clear it, rotate out left by one, and set idx = idx+1 mod 2**SEL_W.
REQ-021 SHALL assert wrap for exactly the cycle in which out becomes bit 0 by rotation from the top bit; wrap SHALL be 0 otherwise, including on accepts with in=0.
REQ-022 When en=0 at a rising edge, SHALL clear out, idx, out_valid, wrap, dwell counter and enter IDLE, overriding any accept or scan step.
REQ-023 SHALL leave SCAN only via en=0 or reset; in_valid during SCAN is ignored.
REQ-024 SHALL maintain out == (out_valid ? 1<<idx : 0) in every cycle.
REQ-025 With DWELL=1, SHALL step one position per cycle with no idle cycles.

Reset
REQ-026 On rst=1, SHALL asynchronously set state IDLE, out = 0, idx = 0, out_valid = 0, wrap = 0, dwell counter = 0.
REQ-027 Reset asserted mid-scan SHALL abort the scan immediately; first accept after release SHALL behave as from IDLE.

Configuration
REQ-028 Macro DECODER_SCAN_EN defined: SCAN state, dwell counter, mode and wrap behaviour compiled in as above.
REQ-029 Macro DECODER_SCAN_EN undefined: mode SHALL be ignored (treated as 0), SCAN state and dwell counter absent, wrap tied to 0; all other behaviour unchanged.

Verification (SEL_W=4, DWELL=2, DECODER_SCAN_EN defined unless noted)
REQ-030 Reset then en=1, in_valid=1, mode=0, in=4'h5 -> next cycle out=16'h0020, idx=5, out_valid=1, state HOLD, in_ready=1.
REQ-031 Accepts in=4'h0, 4'hF on consecutive cycles, mode=0 -> out=16'h0001 then 16'h8000, wrap stays 0.
REQ-032 Accept mode=1, in=4'hE -> out=16'h4000 for 2 cycles, 16'h8000 for 2 cycles, then 16'h0001 with wrap=1 for one cycle; in_ready=0 throughout.
REQ-033 During scan drop en for one cycle -> next edge out=0, out_valid=0, idx=0, state IDLE, in_ready=1 once en returns.
REQ-034 rst pulsed asynchronously mid-scan between clock edges -> out=0, out_valid=0 immediately, no wrap pulse.
REQ-035 DECODER_SCAN_EN undefined, accept mode=1, in=4'h3 -> out=16'h0008 held constant, wrap=0, in_ready=1.
